// File: rtl/buffer_pkg.sv
// buffer_pkg: write-side state enum and frame-buffer geometry defaults shared by the buffer,
// its write sequencer and the read side.
package buffer_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, FULL, FLUSH} wr_state_e;
    localparam int DEF_BLOCK_COUNT = 4;
    localparam int DEF_BLOCK_DEPTH = 480;
    localparam int DEF_BLOCK_WIDTH = 32;
    localparam int PIX_PER_WORD    = DEF_BLOCK_WIDTH / 8;
    function automatic int lane_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: collects one colour's bytes into a word lane by lane; lanes beyond the current
// fill level read as zero, so a flush presents a zero-filled partial word.
module pixel_packer
    import buffer_pkg::*;
#(
    parameter int WIDTH  = DEF_BLOCK_WIDTH,
    parameter int LANES  = WIDTH / 8,
    parameter int LANE_W = lane_bits(LANES)
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_shift,
    input  logic              I_flush,
    input  logic [LANE_W-1:0] I_lane,
    input  logic [7:0]        I_byte,
    output logic [WIDTH-1:0]  O_word
);
    logic [LANES-1:0][7:0] r_lanes;
    logic                  w_load;
    assign w_load = I_shift & ~I_flush;
    always_ff @(posedge I_clk or negedge I_rst_n)
        if (!I_rst_n)    r_lanes <= '0;
        else if (w_load) r_lanes[I_lane] <= I_byte;
    // The incoming byte is merged combinationally so a completed word can be written without a cycle of delay
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign O_word[8*k +: 8] = (LANE_W'(k) < I_lane) ? r_lanes[k] :
                                  (LANE_W'(k) == I_lane && w_load) ? I_byte : 8'h00;
    end
endmodule

// File: rtl/buffer_write_sequencer.sv
// buffer_write_sequencer: packs the DVI pixel stream into one word per colour bank and sequences
// block-major writes into the frame buffer. Define BUFFER_STATS_EN for per-frame word/drop count ports.
module buffer_write_sequencer
    import buffer_pkg::*;
#(
    parameter int COLOR_COUNT = 3,
    parameter int BLOCK_COUNT = DEF_BLOCK_COUNT,
    parameter int BLOCK_DEPTH = DEF_BLOCK_DEPTH,
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
    parameter int ADDR_W      = $clog2(BLOCK_DEPTH)
) (
    input  logic                                         I_clk,
    input  logic                                         I_rst_n,
    input  logic                                         I_vsync,
    input  logic                                         I_de,
    input  logic [8*COLOR_COUNT-1:0]                     I_pixel,
    output logic [BLOCK_COUNT-1:0]                       O_cea,
    output logic [ADDR_W-1:0]                            O_ada,
    output logic [BLOCK_WIDTH*COLOR_COUNT-1:0]           O_din,
    output logic                                         O_frame_done,
`ifdef BUFFER_STATS_EN
    output logic [$clog2(BLOCK_COUNT*BLOCK_DEPTH+1)-1:0] O_word_count,
    output logic [15:0]                                  O_drop_count,
`endif
    output logic                                         O_overflow
);
    localparam int LANE_W = lane_bits(BLOCK_WIDTH / 8);
    localparam int BLK_W  = lane_bits(BLOCK_COUNT);

    wr_state_e                          r_state, w_state_nxt;
    logic                               r_vsync, r_flush_wr;
    logic [LANE_W-1:0]                  r_cnt;
    logic [BLK_W-1:0]                   r_blk;
    logic [ADDR_W-1:0]                  r_ada;
    logic [BLOCK_WIDTH*COLOR_COUNT-1:0] w_merged;
    logic w_vs_rise, w_take, w_word_done, w_blk_end, w_last_word, w_flush, w_flush_wr, w_drop, w_done;

    assign w_vs_rise   = I_vsync & ~r_vsync;
    assign w_take      = (r_state == ACTIVE) & I_de;
    assign w_word_done = w_take & (r_cnt == LANE_W'(BLOCK_WIDTH / 8 - 1));
    assign w_blk_end   = r_ada == ADDR_W'(BLOCK_DEPTH - 1);
    assign w_last_word = w_blk_end & (r_blk == BLK_W'(BLOCK_COUNT - 1));
    assign w_flush     = r_state == FLUSH;
    assign w_flush_wr  = w_flush & (r_cnt != '0);
    assign w_drop      = (r_state == FULL) & I_de;
    // With no partial word, frame_done takes the slot the partial write would have used
    assign w_done      = (w_flush & ~w_flush_wr) | r_flush_wr;

    for (genvar c = 0; c < COLOR_COUNT; c++) begin : g_bank
        pixel_packer #(.WIDTH(BLOCK_WIDTH)) u_packer (
            .I_clk   (I_clk),
            .I_rst_n (I_rst_n),
            .I_shift (w_take),
            .I_flush (w_flush),
            .I_lane  (r_cnt),
            .I_byte  (I_pixel[8*c +: 8]),
            .O_word  (w_merged[BLOCK_WIDTH*c +: BLOCK_WIDTH])
        );
    end

    always_ff @(posedge I_clk or negedge I_rst_n)
        if (!I_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_vs_rise ? ACTIVE : IDLE;
            ACTIVE:  w_state_nxt = w_vs_rise ? FLUSH : (w_word_done & w_last_word) ? FULL : ACTIVE;
            FULL:    w_state_nxt = w_vs_rise ? FLUSH : FULL;
            default: w_state_nxt = ACTIVE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vsync      <= 1'b0;
            r_flush_wr   <= 1'b0;
            r_cnt        <= '0;
            r_blk        <= '0;
            r_ada        <= '0;
            O_cea        <= '0;
            O_ada        <= '0;
            O_din        <= '0;
            O_frame_done <= 1'b0;
            O_overflow   <= 1'b0;
        end else begin
            r_vsync      <= I_vsync;
            r_flush_wr   <= w_flush_wr;
            O_frame_done <= w_done;
            O_cea        <= '0;
            if (w_word_done | w_flush_wr) begin
                O_cea <= BLOCK_COUNT'(1) << r_blk;
                O_ada <= r_ada;
                O_din <= w_merged;
            end
            if (w_take) r_cnt <= r_cnt + 1'b1;
            if (w_word_done) begin
                r_ada <= w_blk_end ? '0 : r_ada + 1'b1;
                if (w_blk_end) r_blk <= r_blk + 1'b1;
            end
            if (w_flush) begin
                r_cnt <= '0;
                r_blk <= '0;
                r_ada <= '0;
            end
            if (w_done)      O_overflow <= 1'b0;
            else if (w_drop) O_overflow <= 1'b1;
        end
    end

`ifdef BUFFER_STATS_EN
    logic [$clog2(BLOCK_COUNT*BLOCK_DEPTH+1)-1:0] r_words;
    logic [15:0]                                  r_drops;
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_words      <= '0;
            r_drops      <= '0;
            O_word_count <= '0;
            O_drop_count <= '0;
        end else if (w_flush) begin
            O_word_count <= r_words + $bits(r_words)'(w_flush_wr);
            O_drop_count <= r_drops;
            r_words      <= '0;
            r_drops      <= '0;
        end else begin
            if (w_word_done) r_words <= r_words + 1'b1;
            if (w_drop && r_drops != '1) r_drops <= r_drops + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_buffer_write_sequencer.sv
// tb_buffer_write_sequencer: directed frames against a queue of expected writes and frame-done events;
// a negedge monitor pops and compares whatever the sequencer presents.
module tb_buffer_write_sequencer;
    logic        clk = 1'b0, rst_n = 1'b1, vsync = 1'b0, de = 1'b0;
    logic [23:0] pixel = '0;
    logic [3:0]  cea;
    logic [8:0]  ada;
    logic [95:0] din;
    logic        done, ovf;
`ifdef BUFFER_STATS_EN
    logic [10:0] word_count;
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    buffer_write_sequencer dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_vsync      (vsync),
        .I_de         (de),
        .I_pixel      (pixel),
        .O_cea        (cea),
        .O_ada        (ada),
        .O_din        (din),
        .O_frame_done (done),
`ifdef BUFFER_STATS_EN
        .O_word_count (word_count),
        .O_drop_count (drop_count),
`endif
        .O_overflow   (ovf)
    );

    typedef struct {
        bit          is_done;
        logic [3:0]  cea;
        logic [8:0]  ada;
        logic [95:0] din;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0, last_wr = -100, writes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_wr(input logic [3:0] c, input logic [8:0] a, input logic [95:0] d);
        exp_t e;
        e.is_done = 1'b0; e.cea = c; e.ada = a; e.din = d; e.gap = -1;
        q.push_back(e);
    endfunction

    function automatic void push_done(input int gap);
        exp_t e;
        e.is_done = 1'b1; e.cea = '0; e.ada = '0; e.din = '0; e.gap = gap;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (cea != 4'b0000) begin
            writes++;
            if (q.size() == 0 || q[0].is_done) begin
                tests++; fails++;
                $display("FAIL unexpected write: cea %b ada %0d din %h", cea, ada, din);
            end else begin
                e = q.pop_front();
                check("write cea/ada/din", {cea, ada, din}, {e.cea, e.ada, e.din});
            end
            last_wr = cyc;
        end
        if (done === 1'b1) begin
            if (q.size() == 0 || !q[0].is_done) begin
                tests++; fails++;
                $display("FAIL unexpected frame_done at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                check("overflow cleared at frame_done", ovf, 1'b0);
                if (e.gap >= 0) check("frame_done latency", cyc - last_wr, e.gap);
            end
        end
    end

    task automatic drive(input logic d, input logic v, input logic [23:0] p);
        @(posedge clk); #1;
        de = d; vsync = v; pixel = p;
    endtask

    task automatic vs_edge();
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        check("expected events all seen", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [95:0] w;
        logic [15:0] v;
        int          w0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {cea, ada, din, done, ovf}, '0);
`ifdef BUFFER_STATS_EN
        check("reset stats", {word_count, drop_count}, '0);
`endif
        rst_n = 1'b1;

        // Pixels before the first vsync edge are ignored
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, {8'h20 + 8'(i), 8'h10 + 8'(i), 8'(i)});
        idle(4);
        check("no writes before first vsync", writes, 0);

        // Two full words after frame sync
        vs_edge();
        push_wr(4'b0001, 9'd0, {32'h23222120, 32'h13121110, 32'h03020100});
        push_wr(4'b0001, 9'd1, {32'h27262524, 32'h17161514, 32'h07060504});
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, {8'h20 + 8'(i), 8'h10 + 8'(i), 8'(i)});
        idle(3);
        check("overflow low in fitting frame", ovf, 1'b0);
        push_done(-1);
        vs_edge();
        idle(3);
        drain();

        // Six pixels, sixth coinciding with the vsync edge: partial word, then frame_done next cycle
        push_wr(4'b0001, 9'd0, {32'hC3C2C1C0, 32'hB3B2B1B0, 32'hA3A2A1A0});
        push_wr(4'b0001, 9'd1, {32'h0000C5C4, 32'h0000B5B4, 32'h0000A5A4});
        push_done(1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, {8'hC0 + 8'(i), 8'hB0 + 8'(i), 8'hA0 + 8'(i)});
        check("overflow low before partial flush", ovf, 1'b0);
        drive(1'b1, 1'b1, 24'hC5B5A5);
        idle(4);
        drain();
`ifdef BUFFER_STATS_EN
        check("word_count partial frame", word_count, 11'd2);
`endif

        // 100-pixel frame restarts at ada 0 / cea 0001
        for (int k = 0; k < 25; k++) begin
            for (int j = 0; j < 4; j++) begin
                w[8*j +: 8]      = 8'(4*k + j);
                w[32 + 8*j +: 8] = ~8'(4*k + j);
                w[64 + 8*j +: 8] = 8'h77;
            end
            push_wr(4'b0001, 9'(k), w);
        end
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, {8'h77, ~8'(i), 8'(i)});
        idle(2);
        push_done(-1);
        vs_edge();
        idle(3);
        drain();
`ifdef BUFFER_STATS_EN
        check("word_count 100 pixels", word_count, 11'd25);
        check("drop_count 100 pixels", drop_count, 16'd0);
`endif

        // Over-full frame: 1920 words fill all blocks, the 1921st word's pixels are dropped
        for (int k = 0; k < 1920; k++) begin
            for (int j = 0; j < 4; j++) begin
                v = 16'(4*k + j);
                w[8*j +: 8]      = v[7:0];
                w[32 + 8*j +: 8] = v[15:8];
                w[64 + 8*j +: 8] = 8'hC3;
            end
            push_wr(4'b0001 << (k / 480), 9'(k % 480), w);
        end
        for (int i = 0; i < 7684; i++) begin
            v = 16'(i);
            drive(1'b1, 1'b0, {8'hC3, v[15:8], v[7:0]});
        end
        idle(2);
        check("overflow set after drops", ovf, 1'b1);
        check("all buffer words written", q.size(), 0);
        push_done(-1);
        vs_edge();
        idle(3);
        check("overflow cleared after flush", ovf, 1'b0);
        drain();
`ifdef BUFFER_STATS_EN
        check("word_count full frame", word_count, 11'd1920);
        check("drop_count full frame", drop_count, 16'd4);
`endif

        // Reset with two bytes pending aborts the frame silently
        drive(1'b1, 1'b0, 24'h111111);
        drive(1'b1, 1'b0, 24'h222222);
        @(posedge clk); #2;
        de = 1'b0; rst_n = 1'b0;
        #1;
        check("outputs zero in mid-frame reset", {cea, ada, din, done, ovf}, '0);
`ifdef BUFFER_STATS_EN
        check("stats zero in mid-frame reset", {word_count, drop_count}, '0);
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        w0 = writes;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 24'h333333);
        idle(3);
        check("idle after reset until vsync", writes - w0, 0);
        vs_edge();
        push_wr(4'b0001, 9'd0, {32'h93929190, 32'h83828180, 32'h73727170});
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, {8'h90 + 8'(i), 8'h80 + 8'(i), 8'h70 + 8'(i)});
        idle(2);
        push_done(-1);
        vs_edge();
        idle(3);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
